// File: rtl/ara_pkg.sv
// Shared sequencer/PE types: instruction IDs, VFU selector, request and response records.
package ara_pkg;

  localparam int unsigned NrVInsn = 8;

  typedef logic [$clog2(NrVInsn)-1:0] vid_t;

  typedef enum logic [2:0] {
    VFU_None,
    VFU_Alu,
    VFU_MFpu,
    VFU_SlideUnit,
    VFU_MaskUnit,
    VFU_LoadUnit,
    VFU_StoreUnit
  } vfu_e;

  localparam int unsigned NrVFUs = 7;

  typedef enum logic [2:0] {
    VADD,
    VSUB,
    VMUL,
    VLE,
    VSE,
    VSLIDEUP
  } ara_op_e;

  typedef struct packed {
    vid_t               id;
    ara_op_e            op;
    vfu_e               vfu;
    logic [4:0]         vs1;
    logic [4:0]         vs2;
    logic [4:0]         vd;
    logic               vm;
    logic [15:0]        vl;
    logic [NrVInsn-1:0] hazard_vs1;
    logic [NrVInsn-1:0] hazard_vs2;
    logic [NrVInsn-1:0] hazard_vd;
    logic [NrVInsn-1:0] hazard_vm;
  } pe_req_t;

  typedef struct packed {
    logic [NrVInsn-1:0] vinsn_done;
    logic               exception;
  } pe_resp_t;

endpackage

// File: rtl/pe_vinsn_queue.sv
// Per-PE instruction queue: captures each broadcast request once, holds it in a
// circular buffer, exposes the oldest entry with live hazard masking, and reports
// completion to the sequencer with a one-cycle registered done pulse.
module pe_vinsn_queue
  import ara_pkg::*;
#(
  parameter int unsigned       NrLanes         = 1,
  parameter int unsigned       VInsnQueueDepth = 4,
  parameter logic [NrVFUs-1:0] AcceptVfuMask   = '1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  pe_req_t            pe_req_i,
  input  logic               pe_req_valid_i,
  output logic               pe_req_ready_o,
  input  logic [NrVInsn-1:0] vinsn_running_i,
  output pe_req_t            head_o,
  output logic               head_valid_o,
  output logic               head_hazard_free_o,
  input  logic               exec_done_i,
  output pe_resp_t           pe_resp_o
);

  localparam int unsigned PtrW = $clog2(VInsnQueueDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(VInsnQueueDepth);

  typedef logic [PtrW-1:0] ptr_t;

  // Elaboration-time parameter sanity checks
  if (NrLanes == 0) begin : g_chk_lanes
    $error("NrLanes must be at least 1");
  end
  if ((VInsnQueueDepth < 2) || ((VInsnQueueDepth & (VInsnQueueDepth - 1)) != 0)) begin : g_chk_depth
    $error("VInsnQueueDepth must be a power of two and at least 2");
  end

  pe_req_t            mem_q [VInsnQueueDepth];
  ptr_t               rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]    cnt_q;
  logic               seen_q;
  vid_t               seen_id_q;
  logic [NrVInsn-1:0] done_q, done_d;

  logic is_new, vfu_accepted, push, pop;

  // Oldest entry with hazards filtered by what is still running
  always_comb begin
    head_o             = mem_q[rd_ptr_q];
    head_o.hazard_vs1  = mem_q[rd_ptr_q].hazard_vs1 & vinsn_running_i;
    head_o.hazard_vs2  = mem_q[rd_ptr_q].hazard_vs2 & vinsn_running_i;
    head_o.hazard_vd   = mem_q[rd_ptr_q].hazard_vd  & vinsn_running_i;
    head_o.hazard_vm   = mem_q[rd_ptr_q].hazard_vm  & vinsn_running_i;
    head_valid_o       = (cnt_q != '0);
    head_hazard_free_o = head_valid_o &&
                         ~|(head_o.hazard_vs1 | head_o.hazard_vs2 |
                            head_o.hazard_vd  | head_o.hazard_vm);
  end

  // Handshake decode: a held request counts as new only until its ID is recorded
  always_comb begin
    pe_req_ready_o = (cnt_q < Full);
    is_new         = pe_req_valid_i && (!seen_q || (pe_req_i.id != seen_id_q));
    vfu_accepted   = AcceptVfuMask[pe_req_i.vfu];
    push           = is_new && pe_req_ready_o && vfu_accepted;
    pop            = exec_done_i && head_valid_o;
  end

  // One-hot done vector for the entry leaving the queue
  always_comb begin
    done_d = '0;
    if (pop) begin
      done_d[mem_q[rd_ptr_q].id] = 1'b1;
    end
  end

  // Response record: only the done field is ever driven
  always_comb begin
    pe_resp_o            = '0;
    pe_resp_o.vinsn_done = done_q;
  end

  // Filtered-out requests are still marked seen so they are not re-evaluated
  // every cycle; a full queue leaves the record untouched so the request retries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seen_q    <= 1'b0;
      seen_id_q <= '0;
    end else if (!pe_req_valid_i) begin
      seen_q    <= 1'b0;
    end else if (is_new && pe_req_ready_o) begin
      seen_q    <= 1'b1;
      seen_id_q <= pe_req_i.id;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the depth
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage, written at the tail, never reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pe_req_i;
    end
  end

  // Registered completion pulse, lasts exactly one cycle per pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= '0;
    end else begin
      done_q <= done_d;
    end
  end

endmodule

// File: doc/pe_vinsn_queue.md
PE_VINSN_QUEUE -- requirements
Module: pe_vinsn_queue

Interface
REQ-001 Parameter NrLanes, default 1, number of vector lanes; used only for package-derived widths.
REQ-002 Parameter VInsnQueueDepth, default 4, number of queue entries; power of two, at least 2.
REQ-003 Parameter AcceptVfuMask, default all ones, one bit per vfu_e value; selects which VFUs this PE accepts.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk_i  input  1  clock.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 pe_req_i  input  pe_req_t  broadcast request from the sequencer.
REQ-008 pe_req_valid_i  input  1  request valid; held high by the sequencer until all PEs are ready.
REQ-009 pe_req_ready_o  output  1  queue can take one more entry.
REQ-010 vinsn_running_i  input  NrVInsn  currently running instruction IDs, from the sequencer.
REQ-011 head_o  output  pe_req_t  oldest queued request.
REQ-012 head_valid_o  output  1  queue not empty.
REQ-013 head_hazard_free_o  output  1  head may start operand fetch.
REQ-014 exec_done_i  input  1  execution unit has finished the head instruction; pops the head.
REQ-015 pe_resp_o  output  pe_resp_t  completion report to the sequencer.

Function
REQ-016 pe_req_ready_o SHALL be 1 iff entry count < VInsnQueueDepth, derived from registered count only and independent of pe_req_valid_i.
REQ-017 An incoming request SHALL be "new" iff pe_req_valid_i && (!seen_q || pe_req_i.id != seen_id_q).
REQ-018 A push SHALL occur iff the request is new, pe_req_ready_o = 1, and AcceptVfuMask[pe_req_i.vfu] = 1.
REQ-019 On a push, seen_q SHALL be set and seen_id_q SHALL load pe_req_i.id, so a held request is queued exactly once.
REQ-020 When the request is new and its VFU is filtered out, seen_q and seen_id_q SHALL update the same way, and no entry SHALL be written.
REQ-021 seen_q SHALL clear whenever pe_req_valid_i = 0.
REQ-022 When the request is new but pe_req_ready_o = 0, no update SHALL occur; the sequencer holds the request and it SHALL be retried.
REQ-023 The queue SHALL be a circular buffer with read and write pointers of log2(VInsnQueueDepth) bits that wrap modulo depth, and a count of log2(VInsnQueueDepth)+1 bits.
REQ-024 A pushed entry SHALL be visible on head_o at the earliest one cycle after the push; there is no bypass.
REQ-025 head_o SHALL be the stored entry with hazard_vs1, hazard_vs2, hazard_vd and hazard_vm each ANDed with vinsn_running_i every cycle.
REQ-026 head_hazard_free_o SHALL equal head_valid_o && none of the masked hazard bits set.
REQ-027 A pop SHALL occur iff exec_done_i && head_valid_o.
REQ-028 exec_done_i while the queue is empty SHALL be ignored.
REQ-029 A simultaneous push and pop SHALL leave the count unchanged; both pointers advance.
REQ-030 Push at full is impossible because ready is low (REQ-016).
REQ-031 On a pop, pe_resp_o.vinsn_done SHALL be one-hot at the popped entry's id in the following cycle, for exactly one cycle; it is registered.
REQ-032 pe_resp_o.vinsn_done SHALL be zero at all other times.
REQ-033 All other pe_resp_o fields SHALL be zero.
REQ-034 Entries SHALL pop strictly in push order.

Reset
REQ-035 On reset, count, pointers, seen_q and seen_id_q SHALL be 0.
REQ-036 On reset, pe_resp_o SHALL be '0; head_valid_o and head_hazard_free_o SHALL be 0; pe_req_ready_o SHALL be 1.
REQ-037 Entry storage need not be reset; head_o is don't-care while head_valid_o = 0.
REQ-038 Reset asserted mid-operation SHALL discard all entries and any pending done pulse immediately.

Structure
REQ-039 pe_req_t, pe_resp_t, vfu_e and NrVInsn SHALL come from ara_pkg; the module adds no new package types.
REQ-040 VInsnQueueDepth SHALL stay a module parameter, not a package constant.
REQ-041 The module SHALL be flat, with no sub-modules; storage is an inline register array.

Verification
REQ-042 Reset, then push id 3 (VFU_Alu), valid held 3 cycles -> exactly one entry; head_valid_o = 1 the next cycle; count = 1.
REQ-043 Depth 4: push ids 0,1,2,3 back-to-back -> ready drops after the 4th push; a 5th request with id 4 is held; one exec_done_i -> vinsn_done = 0x01 next cycle, and id 4 is accepted the cycle after ready rises.
REQ-044 Head id 2 with hazard_vs1 = 0x01 and vinsn_running_i = 0x01 -> head_hazard_free_o = 0; drop vinsn_running_i bit 0 -> head_hazard_free_o = 1 in the same cycle.
REQ-045 Count 2, simultaneous push of id 5 and exec_done_i -> count stays 2; vinsn_done one-hot for the old head; id 5 becomes the tail.
REQ-046 AcceptVfuMask excluding VFU_LoadUnit, VLE request with id 1 -> no push, no done; a following VADD with id 2 is accepted.
REQ-047 Reset asserted with 3 entries and a done pending -> all outputs at reset values the same cycle; vinsn_done never pulses.
